// File: rtl/neander_uart_io.sv
// rtl/neander_uart_io.sv - UART peripheral on the NEANDER-X I/O port
module neander_uart_io #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] io_out,
    input  logic       io_write,
    input  logic       io_read,
    output logic [7:0] io_in,
    output logic [7:0] io_status,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(TX_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          tx_full, fifo_nonempty, tx_push, tx_pop, tx_empty;

    tx_state_t     tx_state;
    logic [BW-1:0] tx_baud;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    rx_state_t     rx_state;
    logic [BW-1:0] rx_baud;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_meta, rx_sync, rx_valid, rx_overrun, rx_done;

    assign tx_full       = (fifo_count == CW'(TX_DEPTH));
    assign fifo_nonempty = (fifo_count != '0);
    assign tx_push       = io_write && !tx_full;
    // Pop only when the serializer is ready to load a new byte.
    assign tx_pop        = fifo_nonempty &&
                           ((tx_state == TX_IDLE) ||
                            (tx_state == TX_STOP && tx_baud == BAUD_LAST));
    assign tx_empty      = !fifo_nonempty && (tx_state == TX_IDLE);
    assign io_status     = {4'b0000, rx_overrun, tx_empty, tx_full, rx_valid};

    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr] <= io_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // uart_tx trails the state by one cycle, so every bit keeps its full width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    if (fifo_nonempty) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_baud  <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    uart_tx <= 1'b0;
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    uart_tx <= tx_shift[0];
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud  <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) begin
                            tx_bit   <= '0;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        if (fifo_nonempty) begin
                            tx_shift <= fifo_mem[rd_ptr];
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_done = (rx_state == RX_STOP) && (rx_baud == BAUD_LAST) && rx_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            rx_baud    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            io_in      <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
            endcase

            // A completing byte beats a simultaneous acknowledge.
            if (rx_done) begin
                io_in      <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid && !io_read;
            end else if (io_read) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neander_uart_io.sv
// tb/tb_neander_uart_io.sv - directed bench for neander_uart_io
module tb_neander_uart_io;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] io_out = 8'h00;
    logic       io_write = 1'b0;
    logic       io_read = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_status;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    int         passed = 0;
    int         total = 0;

    neander_uart_io #(.CLKS_PER_BIT(16), .TX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .io_out(io_out), .io_write(io_write),
        .io_read(io_read), .io_in(io_in), .io_status(io_status),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts `lead` cycles before mid start bit; ends at mid stop bit.
    task automatic check_frame(input logic [7:0] b, input int lead);
        wait_cyc(lead);
        check("tx_start_bit", {7'd0, uart_tx}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(16);
            check("tx_data_bit", {7'd0, uart_tx}, {7'd0, b[i]});
        end
        wait_cyc(16);
        check("tx_stop_bit", {7'd0, uart_tx}, 8'h01);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic rd_at_stop);
        uart_rx = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cyc(16);
        end
        uart_rx = stop;
        for (int j = 0; j < 16; j++) begin
            io_read = rd_at_stop && (j == 10);
            @(negedge clk);
        end
        io_read = 1'b0;
        uart_rx = 1'b1;
    endtask

    task automatic pulse_read();
        io_read = 1'b1;
        @(negedge clk);
        io_read = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes6 [6];
        int lows;
        bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        wait_cyc(3);
        check("reset_tx", {7'd0, uart_tx}, 8'h01);
        check("reset_in", io_in, 8'h00);
        check("reset_status", io_status, 8'h04);
        reset = 1'b1;
        wait_cyc(3);

        io_out = 8'hA5;
        io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0;
        check("a5_busy_status", io_status, 8'h00);
        @(negedge clk);
        check("a5_latency_high", {7'd0, uart_tx}, 8'h01);
        @(negedge clk);
        check("a5_latency_fall", {7'd0, uart_tx}, 8'h00);
        check_frame(8'hA5, 8);
        wait_cyc(6);
        check("a5_not_yet_empty", io_status, 8'h00);
        wait_cyc(1);
        check("a5_empty", io_status, 8'h04);
        wait_cyc(10);

        for (int k = 0; k < 5; k++) begin
            io_out = 8'(k + 1);
            io_write = 1'b1;
            @(negedge clk);
        end
        io_write = 1'b0;
        check_frame(8'h01, 6);
        for (int k = 1; k < 5; k++) check_frame(8'(k + 1), 16);
        wait_cyc(7);
        check("five_empty", io_status, 8'h04);
        wait_cyc(10);

        for (int k = 0; k < 6; k++) begin
            io_out = bytes6[k];
            io_write = 1'b1;
            @(negedge clk);
        end
        io_write = 1'b0;
        check("six_full", io_status, 8'h02);
        check_frame(bytes6[0], 5);
        for (int k = 1; k < 5; k++) check_frame(bytes6[k], 16);
        wait_cyc(7);
        check("six_empty", io_status, 8'h04);
        wait_cyc(50);
        check("six_dropped_idle", {7'd0, uart_tx}, 8'h01);

        send_rx(8'h3C, 1'b1, 1'b0);
        wait_cyc(4);
        check("rx_3c_in", io_in, 8'h3C);
        check("rx_3c_status", io_status, 8'h05);
        pulse_read();
        check("rx_read_status", io_status, 8'h04);
        check("rx_read_in", io_in, 8'h3C);

        send_rx(8'h11, 1'b1, 1'b0);
        send_rx(8'h22, 1'b1, 1'b0);
        wait_cyc(4);
        check("rx_overrun_in", io_in, 8'h22);
        check("rx_overrun_status", io_status, 8'h0D);

        send_rx(8'h33, 1'b1, 1'b1);
        wait_cyc(4);
        check("rx_coincide_in", io_in, 8'h33);
        check("rx_coincide_status", io_status, 8'h05);
        pulse_read();
        check("rx_read2_status", io_status, 8'h04);

        uart_rx = 1'b0;
        wait_cyc(4);
        uart_rx = 1'b1;
        wait_cyc(30);
        check("glitch_status", io_status, 8'h04);
        check("glitch_in", io_in, 8'h33);

        send_rx(8'h55, 1'b0, 1'b0);
        wait_cyc(30);
        check("framing_status", io_status, 8'h04);
        check("framing_in", io_in, 8'h33);

        for (int k = 0; k < 3; k++) begin
            io_out = 8'hF0 + 8'(k);
            io_write = 1'b1;
            @(negedge clk);
        end
        io_write = 1'b0;
        wait_cyc(40);
        check("pre_reset_tx_low", {7'd0, uart_tx}, 8'h00);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tx", {7'd0, uart_tx}, 8'h01);
        check("async_reset_status", io_status, 8'h04);
        check("async_reset_in", io_in, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        lows = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("flush_no_frame", 8'(lows), 8'h00);
        check("flush_status", io_status, 8'h04);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
